ym6045c_bus_grant_ctrl: RTL and testbench



---
 rtl/ym6045c_arb_pkg.sv | 36 +++
 rtl/ym6045c_rfsh_timer.sv | 42 ++++
 rtl/ym6045c_bus_grant_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ym6045c_bus_grant_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym6045c_arb_pkg.sv
// Shared types and defaults for the YM6045C 68000 bus-grant controller.
// Holds the FSM state enum, the owner encoding and the parameter defaults
// used by ym6045c_bus_grant_ctrl and ym6045c_rfsh_timer.
package ym6045c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK,
    HOLD,
    SWITCH,
    REL
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RFSH = 2'd1,
    OWN_VDP  = 2'd2,
    OWN_Z80  = 2'd3
  } owner_e;

  localparam int unsigned RFSH_PERIOD_DEF = 128;
  localparam int unsigned RFSH_LEN_DEF    = 4;
  localparam int unsigned BG_TIMEOUT_DEF  = 255;
  localparam int unsigned MAX_CHAIN_DEF   = 2;

  // Fixed priority: refresh > VDP > Z80.
  function automatic owner_e pick_winner(input logic rfsh, input logic vdp,
                                         input logic z80);
    if (rfsh)     return OWN_RFSH;
    else if (vdp) return OWN_VDP;
    else if (z80) return OWN_Z80;
    else          return OWN_NONE;
  endfunction

endpackage

// File: rtl/ym6045c_rfsh_timer.sv
// DRAM refresh request timer.
// Counts 0..RFSH_PERIOD-1 on MCLK; each wrap raises rfsh_pend, which stays
// high until the controller pulses clr (on the edge that enters a refresh
// HOLD). A wrap while already pending is absorbed (no queueing).
// Ports:
//   MCLK      in   master clock
//   RESET     in   synchronous active-high reset
//   clr       in   clear the pending refresh request
//   rfsh_pend out  refresh request pending
module ym6045c_rfsh_timer
  import ym6045c_arb_pkg::*;
#(
  parameter int unsigned RFSH_PERIOD = RFSH_PERIOD_DEF
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic clr,
  output logic rfsh_pend
);

  localparam int unsigned CW = $clog2(RFSH_PERIOD);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(RFSH_PERIOD - 1));

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      cnt       <= '0;
      rfsh_pend <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // A fresh wrap wins over a simultaneous clear so that period is not lost.
      if (wrap)
        rfsh_pend <= 1'b1;
      else if (clr)
        rfsh_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ym6045c_bus_grant_ctrl.sv
// YM6045C 68000 bus-sharing controller.
// Acquires the 68000 bus through BR/BG/BGACK on behalf of DRAM refresh,
// VDP DMA and Z80 banked access, grants by fixed priority without
// preemption (up to MAX_CHAIN grants per tenure), then releases the bus.
// Ports:
//   MCLK, RESET               clock, synchronous active-high reset
//   m68k_bg_n, m68k_as_n      68000 bus grant / address strobe (registered)
//   m68k_br_n, m68k_bgack_n   bus request / bus grant acknowledge
//   vdp_req, z80_req          level requests, held until done
//   rfsh_gnt, vdp_gnt, z80_gnt  one-hot (or zero) grants
//   owner                     0 none, 1 refresh, 2 VDP, 3 Z80
//   busy                      state != IDLE
//   err_timeout               sticky BG timeout flag
module ym6045c_bus_grant_ctrl
  import ym6045c_arb_pkg::*;
#(
  parameter int unsigned RFSH_PERIOD = RFSH_PERIOD_DEF,
  parameter int unsigned RFSH_LEN    = RFSH_LEN_DEF,
  parameter int unsigned BG_TIMEOUT  = BG_TIMEOUT_DEF,
  parameter int unsigned MAX_CHAIN   = MAX_CHAIN_DEF
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       m68k_bg_n,
  input  logic       m68k_as_n,
  output logic       m68k_br_n,
  output logic       m68k_bgack_n,
  input  logic       vdp_req,
  input  logic       z80_req,
  output logic       rfsh_gnt,
  output logic       vdp_gnt,
  output logic       z80_gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       err_timeout
);

  localparam int unsigned WCW = $clog2(BG_TIMEOUT + 1);
  localparam int unsigned HCW = $clog2(RFSH_LEN + 1);
  localparam int unsigned CHW = $clog2(MAX_CHAIN + 1);

  state_e         state_q, state_d;
  owner_e         win_q, win_d;
  logic [CHW-1:0] chain_q, chain_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic           bg_q, as_q;
  logic           rfsh_pend, rfsh_clr;
  logic           any_req, hold_done, err_set;

  logic           br_n_d, bgack_n_d, busy_d;
  logic           rfsh_gnt_d, vdp_gnt_d, z80_gnt_d;
  owner_e         own_d;

  ym6045c_rfsh_timer #(
    .RFSH_PERIOD(RFSH_PERIOD)
  ) u_rfsh_timer (
    .MCLK     (MCLK),
    .RESET    (RESET),
    .clr      (rfsh_clr),
    .rfsh_pend(rfsh_pend)
  );

  assign any_req = rfsh_pend | vdp_req | z80_req;

  // ACK and SWITCH always lead into HOLD, so this is the HOLD-entry edge.
  assign rfsh_clr = ((state_q == ACK) || (state_q == SWITCH)) && (win_q == OWN_RFSH);

  // State register and FSM bookkeeping
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      win_q       <= OWN_NONE;
      chain_q     <= '0;
      wcnt_q      <= '0;
      hcnt_q      <= '0;
      bg_q        <= 1'b1;
      as_q        <= 1'b1;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      chain_q <= chain_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      bg_q    <= m68k_bg_n;
      as_q    <= m68k_as_n;
      if (err_set)
        err_timeout <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    chain_d   = chain_q;
    wcnt_d    = wcnt_q;
    hcnt_d    = hcnt_q;
    err_set   = 1'b0;
    hold_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = REQ;
          // Counts REQ cycles including the current one.
          wcnt_d  = WCW'(1);
        end
      end
      REQ: begin
        if (!bg_q && as_q) begin
          state_d = ACK;
          win_d   = pick_winner(rfsh_pend, vdp_req, z80_req);
          chain_d = CHW'(1);
        end else if (!any_req) begin
          state_d = IDLE;
        end else if (wcnt_q == WCW'(BG_TIMEOUT)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = HOLD;
        hcnt_d  = '0;
      end
      HOLD: begin
        case (win_q)
          OWN_RFSH: hold_done = (hcnt_q == HCW'(RFSH_LEN - 1));
          OWN_VDP:  hold_done = !vdp_req;
          OWN_Z80:  hold_done = !z80_req;
          default:  hold_done = 1'b1;
        endcase
        hcnt_d = hcnt_q + 1'b1;
        if (hold_done) begin
          if (any_req && (chain_q < CHW'(MAX_CHAIN))) begin
            state_d = SWITCH;
            win_d   = pick_winner(rfsh_pend, vdp_req, z80_req);
            chain_d = chain_q + 1'b1;
          end else begin
            state_d = REL;
          end
        end
      end
      SWITCH: begin
        state_d = HOLD;
        hcnt_d  = '0;
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered
  // and still line up with the state they belong to.
  always_comb begin
    br_n_d     = 1'b1;
    bgack_n_d  = 1'b1;
    own_d      = OWN_NONE;
    busy_d     = (state_d != IDLE);
    rfsh_gnt_d = 1'b0;
    vdp_gnt_d  = 1'b0;
    z80_gnt_d  = 1'b0;
    case (state_d)
      REQ: begin
        br_n_d = 1'b0;
      end
      ACK, SWITCH: begin
        bgack_n_d = 1'b0;
        own_d     = win_d;
      end
      HOLD: begin
        bgack_n_d  = 1'b0;
        own_d      = win_d;
        rfsh_gnt_d = (win_d == OWN_RFSH);
        vdp_gnt_d  = (win_d == OWN_VDP);
        z80_gnt_d  = (win_d == OWN_Z80);
      end
      default: begin
        br_n_d = 1'b1;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      m68k_br_n    <= 1'b1;
      m68k_bgack_n <= 1'b1;
      rfsh_gnt     <= 1'b0;
      vdp_gnt      <= 1'b0;
      z80_gnt      <= 1'b0;
      owner        <= OWN_NONE;
      busy         <= 1'b0;
    end else begin
      m68k_br_n    <= br_n_d;
      m68k_bgack_n <= bgack_n_d;
      rfsh_gnt     <= rfsh_gnt_d;
      vdp_gnt      <= vdp_gnt_d;
      z80_gnt      <= z80_gnt_d;
      owner        <= own_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_ym6045c_bus_grant_ctrl.sv
// Directed bench for ym6045c_bus_grant_ctrl.
module tb_ym6045c_bus_grant_ctrl;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic       m68k_bg_n, m68k_as_n;
  logic       m68k_br_n, m68k_bgack_n;
  logic       vdp_req, z80_req;
  logic       rfsh_gnt, vdp_gnt, z80_gnt;
  logic [1:0] owner;
  logic       busy, err_timeout;
  logic [8:0] outs;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  localparam logic [8:0] RST_OUTS = 9'b1_1_000_00_0_0;

  always #5 MCLK = ~MCLK;

  assign outs = {m68k_br_n, m68k_bgack_n, rfsh_gnt, vdp_gnt, z80_gnt, owner, busy, err_timeout};

  ym6045c_bus_grant_ctrl #(
    .RFSH_PERIOD(128),
    .RFSH_LEN   (4),
    .BG_TIMEOUT (255),
    .MAX_CHAIN  (2)
  ) dut (
    .MCLK        (MCLK),
    .RESET       (RESET),
    .m68k_bg_n   (m68k_bg_n),
    .m68k_as_n   (m68k_as_n),
    .m68k_br_n   (m68k_br_n),
    .m68k_bgack_n(m68k_bgack_n),
    .vdp_req     (vdp_req),
    .z80_req     (z80_req),
    .rfsh_gnt    (rfsh_gnt),
    .vdp_gnt     (vdp_gnt),
    .z80_gnt     (z80_gnt),
    .owner       (owner),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic tick();
    @(posedge MCLK);
    @(negedge MCLK);
  endtask

  // Two reset edges with idle inputs; returns at a negedge with RESET low.
  task automatic apply_reset();
    RESET     = 1'b1;
    m68k_bg_n = 1'b1;
    m68k_as_n = 1'b1;
    vdp_req   = 1'b0;
    z80_req   = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned first;
    RESET     = 1'b1;
    m68k_bg_n = 1'b1;
    m68k_as_n = 1'b1;
    vdp_req   = 1'b0;
    z80_req   = 1'b0;
    repeat (300) tick();
    n_total++;
    if (outs !== RST_OUTS) $display("FAIL reset_outs: got %b want %b", outs, RST_OUTS);
    else n_pass++;
    RESET = 1'b0;
    first = 0;
    for (int unsigned n = 1; n <= 140; n++) begin
      tick();
      if (!m68k_br_n && first == 0) first = n;
    end
    n_total++;
    if (first !== 129) $display("FAIL rfsh_first_br: got edge %0d want edge 129", first);
    else n_pass++;
  endtask

  task automatic test_vdp();
    int unsigned gcount;
    apply_reset();
    vdp_req = 1'b1;
    tick();
    n_total++;
    if (m68k_br_n !== 1'b0 || busy !== 1'b1) $display("FAIL vdp_br: got br_n=%b busy=%b want 0 1", m68k_br_n, busy);
    else n_pass++;
    tick();
    tick();
    m68k_bg_n = 1'b0;
    tick();
    n_total++;
    if (m68k_bgack_n !== 1'b1) $display("FAIL vdp_pre_ack: got bgack_n=%b want 1", m68k_bgack_n);
    else n_pass++;
    tick();
    n_total++;
    if ({m68k_br_n, m68k_bgack_n, vdp_gnt} !== 3'b100)
      $display("FAIL vdp_ack: got br_n,bgack_n,gnt=%b want 100", {m68k_br_n, m68k_bgack_n, vdp_gnt});
    else n_pass++;
    m68k_bg_n = 1'b1;
    tick();
    n_total++;
    if (vdp_gnt !== 1'b1 || owner !== 2'd2) $display("FAIL vdp_hold: got gnt=%b owner=%0d want 1 2", vdp_gnt, owner);
    else n_pass++;
    gcount = 1;
    for (int unsigned i = 0; i < 9; i++) begin
      tick();
      if (vdp_gnt) gcount++;
    end
    n_total++;
    if (gcount !== 10) $display("FAIL vdp_gnt_len: got %0d want 10", gcount);
    else n_pass++;
    vdp_req = 1'b0;
    tick();
    n_total++;
    if (outs !== 9'b1_1_000_00_1_0) $display("FAIL vdp_rel: got %b want %b", outs, 9'b1_1_000_00_1_0);
    else n_pass++;
    tick();
    n_total++;
    if (outs !== RST_OUTS) $display("FAIL vdp_idle: got %b want %b", outs, RST_OUTS);
    else n_pass++;
  endtask

  task automatic test_rfsh_z80();
    int unsigned rcount;
    apply_reset();
    z80_req = 1'b1;
    repeat (128) tick();
    m68k_bg_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (m68k_bgack_n !== 1'b0 || m68k_br_n !== 1'b1) $display("FAIL rz_ack: got bgack_n=%b br_n=%b want 0 1", m68k_bgack_n, m68k_br_n);
    else n_pass++;
    m68k_bg_n = 1'b1;
    tick();
    n_total++;
    if (rfsh_gnt !== 1'b1 || owner !== 2'd1 || z80_gnt !== 1'b0)
      $display("FAIL rz_rfsh_hold: got rfsh=%b z80=%b owner=%0d want 1 0 1", rfsh_gnt, z80_gnt, owner);
    else n_pass++;
    rcount = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (!rfsh_gnt) break;
      rcount++;
      tick();
    end
    n_total++;
    if (rcount !== 4) $display("FAIL rz_rfsh_len: got %0d want 4", rcount);
    else n_pass++;
    n_total++;
    if ({rfsh_gnt, vdp_gnt, z80_gnt, m68k_bgack_n, busy} !== 5'b00001)
      $display("FAIL rz_switch: got gnts,bgack_n,busy=%b want 00001", {rfsh_gnt, vdp_gnt, z80_gnt, m68k_bgack_n, busy});
    else n_pass++;
    tick();
    n_total++;
    if (z80_gnt !== 1'b1 || owner !== 2'd3) $display("FAIL rz_z80_hold: got gnt=%b owner=%0d want 1 3", z80_gnt, owner);
    else n_pass++;
    z80_req = 1'b0;
    tick();
    n_total++;
    if (outs !== 9'b1_1_000_00_1_0) $display("FAIL rz_rel: got %b want %b", outs, 9'b1_1_000_00_1_0);
    else n_pass++;
  endtask

  task automatic test_chain_limit();
    apply_reset();
    vdp_req = 1'b1;
    z80_req = 1'b1;
    repeat (128) tick();
    m68k_bg_n = 1'b0;
    tick();
    tick();
    m68k_bg_n = 1'b1;
    tick();
    n_total++;
    if (rfsh_gnt !== 1'b1) $display("FAIL ch_rfsh_first: got rfsh_gnt=%b want 1", rfsh_gnt);
    else n_pass++;
    repeat (4) tick();
    n_total++;
    if ({rfsh_gnt, vdp_gnt, z80_gnt} !== 3'b000) $display("FAIL ch_switch: got gnts=%b want 000", {rfsh_gnt, vdp_gnt, z80_gnt});
    else n_pass++;
    tick();
    n_total++;
    if (vdp_gnt !== 1'b1 || owner !== 2'd2) $display("FAIL ch_vdp: got gnt=%b owner=%0d want 1 2", vdp_gnt, owner);
    else n_pass++;
    tick();
    vdp_req = 1'b0;
    tick();
    n_total++;
    if (outs !== 9'b1_1_000_00_1_0) $display("FAIL ch_rel: got %b want %b", outs, 9'b1_1_000_00_1_0);
    else n_pass++;
    tick();
    n_total++;
    if (m68k_br_n !== 1'b1 || busy !== 1'b0) $display("FAIL ch_idle: got br_n=%b busy=%b want 1 0", m68k_br_n, busy);
    else n_pass++;
    tick();
    n_total++;
    if (m68k_br_n !== 1'b0) $display("FAIL ch_rebr: got br_n=%b want 0", m68k_br_n);
    else n_pass++;
    m68k_bg_n = 1'b0;
    tick();
    tick();
    m68k_bg_n = 1'b1;
    tick();
    n_total++;
    if (z80_gnt !== 1'b1 || owner !== 2'd3) $display("FAIL ch_z80: got gnt=%b owner=%0d want 1 3", z80_gnt, owner);
    else n_pass++;
    z80_req = 1'b0;
    tick();
    tick();
    n_total++;
    if (outs !== RST_OUTS) $display("FAIL ch_end: got %b want %b", outs, RST_OUTS);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int unsigned lcount;
    apply_reset();
    z80_req = 1'b1;
    tick();
    lcount = 0;
    for (int unsigned i = 0; i < 300; i++) begin
      if (m68k_br_n) break;
      lcount++;
      tick();
    end
    n_total++;
    if (lcount !== 255) $display("FAIL to_req_len: got %0d want 255", lcount);
    else n_pass++;
    n_total++;
    if ({m68k_br_n, busy, err_timeout} !== 3'b101)
      $display("FAIL to_flag: got br_n,busy,err=%b want 101", {m68k_br_n, busy, err_timeout});
    else n_pass++;
    z80_req = 1'b0;
    repeat (20) tick();
    n_total++;
    if (err_timeout !== 1'b1) $display("FAIL to_sticky: got err=%b want 1", err_timeout);
    else n_pass++;
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    vdp_req = 1'b1;
    tick();
    m68k_bg_n = 1'b0;
    tick();
    tick();
    tick();
    n_total++;
    if (vdp_gnt !== 1'b1) $display("FAIL rh_pre: got vdp_gnt=%b want 1", vdp_gnt);
    else n_pass++;
    RESET = 1'b1;
    tick();
    n_total++;
    if (outs !== RST_OUTS) $display("FAIL rh_reset: got %b want %b", outs, RST_OUTS);
    else n_pass++;
    RESET   = 1'b0;
    vdp_req = 1'b0;
    m68k_bg_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET     = 1'b1;
    m68k_bg_n = 1'b1;
    m68k_as_n = 1'b1;
    vdp_req   = 1'b0;
    z80_req   = 1'b0;
    @(negedge MCLK);
    test_reset();
    test_vdp();
    test_rfsh_z80();
    test_chain_limit();
    test_timeout();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
